// File: rtl/checkpoint_monitor.sv
// checkpoint_monitor
//   Watches a firmware-driven 16-bit checkpoint bus and sequences an ordered
//   set of tests through start/end markers. It measures the cycles each test
//   spends between its markers, and it flags out-of-order markers and
//   watchdog expiry.
//
//   Marker encoding: test i start = {PREFIX, i, 4'h0}, end = {PREFIX, i, 4'h1}.
//   Any other code that carries PREFIX is a foreign marker. Codes without
//   PREFIX are ignored.
//
// Ports
//   clock        single clock for all logic
//   resetb       asynchronous active-low reset
//   checkbits    checkpoint bus, asynchronous to clock
//   start        arms a run (accepted in IDLE, FINISH or ERROR)
//   clear        synchronous abort to IDLE, clears error flags
//   test_mask    tests to run, sampled with start
//   busy         high in WAIT_START and RUN
//   cur_test     index of the test currently expected
//   done         one-cycle pulse when an end marker is accepted
//   done_test    index of the last completed test (held)
//   done_cycles  start-to-end marker cycles of the last completed test (held)
//   all_done     high in FINISH or ERROR
//   pass         high in FINISH only
//   seq_err      sticky: unexpected prefixed marker accepted
//   timeout_err  sticky: watchdog expired
//   fsm_state    debug view of the sequencer state
//
// Handshake: there is no back-pressure. A new code is accepted once it has
// been stable for STABLE synchronised samples. The resulting code_evt is a
// single-cycle strobe that the sequencer consumes on the following edge.
module checkpoint_monitor #(
    parameter int          NUM_TESTS = 4,
    parameter logic [7:0]  PREFIX    = 8'hAB,
    parameter int          CNT_W     = 32,
    parameter int          STABLE    = 2,
    parameter int          TIMEOUT   = 250000
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic [15:0]          checkbits,
    input  logic                 start,
    input  logic                 clear,
    input  logic [NUM_TESTS-1:0] test_mask,
    output logic                 busy,
    output logic [3:0]           cur_test,
    output logic                 done,
    output logic [3:0]           done_test,
    output logic [CNT_W-1:0]     done_cycles,
    output logic                 all_done,
    output logic                 pass,
    output logic                 seq_err,
    output logic                 timeout_err,
    output logic [2:0]           fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_RUN    = 3'd2,
        S_FINISH = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam int SW = $clog2(STABLE + 1);

    // ------------------------------------------------------------------
    // Input path: 2-flop synchroniser, stability filter, change detector
    // ------------------------------------------------------------------
    logic [15:0]   sync1;
    logic [15:0]   sync2;
    logic [15:0]   samp;       // previous synchronised sample
    logic [15:0]   last_code;  // last accepted code
    logic [SW-1:0] run_len;    // consecutive equal samples, saturates at STABLE
    logic [SW-1:0] run_next;
    logic          code_evt;

    always_comb begin
        run_next = SW'(1);
        if (sync2 == samp) begin
            if (run_len == SW'(STABLE)) begin
                run_next = run_len;
            end else begin
                run_next = run_len + SW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1     <= '0;
            sync2     <= '0;
            samp      <= '0;
            run_len   <= '0;
            last_code <= '0;
            code_evt  <= 1'b0;
        end else begin
            sync1    <= checkbits;
            sync2    <= sync1;
            samp     <= sync2;
            run_len  <= run_next;
            code_evt <= 1'b0;
            // Once saturated the sample equals last_code, so no repeat event.
            if (run_next == SW'(STABLE) && sync2 != last_code) begin
                code_evt  <= 1'b1;
                last_code <= sync2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t               state;
    logic [NUM_TESTS-1:0] mask;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic [CNT_W-1:0]     wd;
    logic                 wd_expire;
    logic                 is_prefixed;
    logic [15:0]          start_code;
    logic [15:0]          end_code;
    logic [4:0]           first_sel;
    logic [4:0]           next_sel;

    // Lowest set bit of m at or above index from; bit 4 flags a hit.
    function automatic logic [4:0] pick(input logic [NUM_TESTS-1:0] m, input int from);
        logic [4:0] r;
        r = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (m[i] && i >= from) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        first_sel   = pick(test_mask, 0);
        next_sel    = pick(mask, int'(cur_test) + 1);
        is_prefixed = (last_code[15:8] == PREFIX);
        start_code  = {PREFIX, cur_test, 4'h0};
        end_code    = {PREFIX, cur_test, 4'h1};
        cnt_inc     = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);
        // Fires on the TIMEOUT-th edge after start.
        wd_expire   = (wd >= CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state       <= S_IDLE;
            mask        <= '0;
            cycle_cnt   <= '0;
            wd          <= '0;
            cur_test    <= '0;
            done        <= 1'b0;
            done_test   <= '0;
            done_cycles <= '0;
            seq_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state       <= S_IDLE;
                seq_err     <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_FINISH, S_ERROR: begin
                        if (start) begin
                            mask        <= test_mask;
                            wd          <= '0;
                            cycle_cnt   <= '0;
                            seq_err     <= 1'b0;
                            timeout_err <= 1'b0;
                            done_test   <= '0;
                            done_cycles <= '0;
                            if (first_sel[4]) begin
                                cur_test <= first_sel[3:0];
                                state    <= S_WAIT;
                            end else begin
                                cur_test <= '0;
                                state    <= S_FINISH;
                            end
                        end
                    end
                    S_WAIT: begin
                        wd <= wd + CNT_W'(1);
                        if (wd_expire) begin
                            timeout_err <= 1'b1;
                            state       <= S_ERROR;
                        end else if (code_evt && is_prefixed) begin
                            if (last_code == start_code) begin
                                cycle_cnt <= '0;
                                state     <= S_RUN;
                            end else begin
                                seq_err <= 1'b1;
                                state   <= S_ERROR;
                            end
                        end
                    end
                    S_RUN: begin
                        wd        <= wd + CNT_W'(1);
                        cycle_cnt <= cnt_inc;
                        if (wd_expire) begin
                            timeout_err <= 1'b1;
                            state       <= S_ERROR;
                        end else if (code_evt && is_prefixed) begin
                            if (last_code == end_code) begin
                                done        <= 1'b1;
                                done_test   <= cur_test;
                                // The end-marker edge itself counts toward the latency.
                                done_cycles <= cnt_inc;
                                if (next_sel[4]) begin
                                    cur_test <= next_sel[3:0];
                                    state    <= S_WAIT;
                                end else begin
                                    state <= S_FINISH;
                                end
                            end else if (last_code != start_code) begin
                                seq_err <= 1'b1;
                                state   <= S_ERROR;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy      = (state == S_WAIT) || (state == S_RUN);
    assign all_done  = (state == S_FINISH) || (state == S_ERROR);
    assign pass      = (state == S_FINISH);
    assign fsm_state = state;

endmodule

// File: tb/tb_checkpoint_monitor.sv
module tb_checkpoint_monitor;

    localparam int CNT_W = 32;

    logic              clock;
    logic              resetb;
    logic [15:0]       checkbits;
    logic              start;
    logic              clear;
    logic [3:0]        test_mask;
    logic              busy;
    logic [3:0]        cur_test;
    logic              done;
    logic [3:0]        done_test;
    logic [CNT_W-1:0]  done_cycles;
    logic              all_done;
    logic              pass;
    logic              seq_err;
    logic              timeout_err;
    logic [2:0]        fsm_state;

    int checks = 0;
    int errors = 0;

    // {done_test, done_cycles}
    logic [35:0] exp_q[$];

    checkpoint_monitor #(
        .NUM_TESTS (4),
        .PREFIX    (8'hAB),
        .CNT_W     (CNT_W),
        .STABLE    (2),
        .TIMEOUT   (500)
    ) dut (
        .clock       (clock),
        .resetb      (resetb),
        .checkbits   (checkbits),
        .start       (start),
        .clear       (clear),
        .test_mask   (test_mask),
        .busy        (busy),
        .cur_test    (cur_test),
        .done        (done),
        .done_test   (done_test),
        .done_cycles (done_cycles),
        .all_done    (all_done),
        .pass        (pass),
        .seq_err     (seq_err),
        .timeout_err (timeout_err),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic drive_code(input logic [15:0] c, input int n);
        checkbits = c;
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start(input logic [3:0] m);
        start     = 1'b1;
        test_mask = m;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic expect_done(input logic [3:0] t, input logic [31:0] cyc);
        exp_q.push_back({t, cyc});
    endtask

    task automatic chk_end(input string tag, input logic p, input logic se, input logic te);
        chk({tag, "_pass"}, 64'(pass), 64'(p));
        chk({tag, "_all_done"}, 64'(all_done), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_seq_err"}, 64'(seq_err), 64'(se));
        chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(te));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_cur_test"}, 64'(cur_test), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_done_test"}, 64'(done_test), 64'd0);
        chk({tag, "_done_cycles"}, 64'(done_cycles), 64'd0);
        chk({tag, "_all_done"}, 64'(all_done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_seq_err"}, 64'(seq_err), 64'd0);
        chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
        chk({tag, "_state"}, 64'(fsm_state), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done_test), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_test", 64'(done_test), 64'(e[35:32]));
                    chk("done_cycles", 64'(done_cycles), 64'(e[31:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        resetb    = 1'b0;
        checkbits = 16'h0000;
        start     = 1'b0;
        clear     = 1'b0;
        test_mask = 4'h0;
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        resetb = 1'b1;
        drive_code(16'h1234, 5);

        // Single test, 100-cycle latency; busy one cycle after start.
        pulse_start(4'b0001);
        chk("single_busy_rise", 64'(busy), 64'd1);
        chk("single_cur_test", 64'(cur_test), 64'd0);
        expect_done(4'd0, 32'd100);
        drive_code(16'hAB00, 100);
        drive_code(16'hAB01, 10);
        chk_end("single", 1'b1, 1'b0, 1'b0);

        // Three tests in order.
        drive_code(16'h1234, 5);
        pulse_start(4'b0111);
        expect_done(4'd0, 32'd20);
        expect_done(4'd1, 32'd30);
        expect_done(4'd2, 32'd7);
        drive_code(16'hAB00, 20);
        drive_code(16'hAB01, 12);
        drive_code(16'hAB10, 30);
        drive_code(16'hAB11, 12);
        drive_code(16'hAB20, 7);
        drive_code(16'hAB21, 10);
        chk_end("three", 1'b1, 1'b0, 1'b0);
        chk("three_held_test", 64'(done_test), 64'd2);
        chk("three_held_cycles", 64'(done_cycles), 64'd7);

        // Sparse mask: cur_test skips from 0 to 2.
        drive_code(16'h1234, 5);
        pulse_start(4'b0101);
        expect_done(4'd0, 32'd15);
        expect_done(4'd2, 32'd25);
        drive_code(16'hAB00, 15);
        drive_code(16'hAB01, 10);
        chk("sparse_cur_test", 64'(cur_test), 64'd2);
        chk("sparse_busy", 64'(busy), 64'd1);
        drive_code(16'hAB20, 25);
        drive_code(16'hAB21, 10);
        chk_end("sparse", 1'b1, 1'b0, 1'b0);

        // Sparse mask with a foreign marker for a skipped test.
        drive_code(16'h1234, 5);
        pulse_start(4'b0101);
        expect_done(4'd0, 32'd15);
        drive_code(16'hAB00, 15);
        drive_code(16'hAB01, 10);
        drive_code(16'hAB10, 10);
        chk_end("seqerr", 1'b0, 1'b1, 1'b0);

        // Empty mask finishes at once and clears the sticky error.
        pulse_start(4'b0000);
        chk_end("empty", 1'b1, 1'b0, 1'b0);

        // Watchdog: timeout_err lands exactly 500 edges after start.
        drive_code(16'h1234, 5);
        pulse_start(4'b0001);
        checkbits = 16'hAB00;
        repeat (499) @(negedge clock);
        chk("timeout_early", 64'(timeout_err), 64'd0);
        chk("timeout_early_busy", 64'(busy), 64'd1);
        @(negedge clock);
        chk_end("timeout", 1'b0, 1'b0, 1'b1);

        // Glitch filter: one-sample AB01 pulse is not accepted.
        drive_code(16'h1234, 5);
        pulse_start(4'b0001);
        drive_code(16'hAB00, 20);
        drive_code(16'hAB01, 1);
        drive_code(16'h1234, 20);
        chk("glitch_state_run", 64'(fsm_state), 64'd2);
        chk("glitch_busy", 64'(busy), 64'd1);
        chk("glitch_pending", 64'(exp_q.size()), 64'd0);
        expect_done(4'd0, 32'd41);
        drive_code(16'hAB01, 10);
        chk_end("glitch", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run.
        drive_code(16'h1234, 5);
        pulse_start(4'b0110);
        expect_done(4'd1, 32'd20);
        drive_code(16'hAB10, 20);
        drive_code(16'hAB11, 10);
        drive_code(16'hAB20, 10);
        chk("midrun_cur_test", 64'(cur_test), 64'd2);
        chk("midrun_done_cycles", 64'(done_cycles), 64'd20);
        chk("midrun_state", 64'(fsm_state), 64'd2);
        #2;
        resetb = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clock);
        resetb = 1'b1;
        drive_code(16'h1234, 5);

        // clear beats start in the same cycle.
        clear     = 1'b1;
        start     = 1'b1;
        test_mask = 4'b0001;
        @(negedge clock);
        clear = 1'b0;
        start = 1'b0;
        chk("clear_start_busy", 64'(busy), 64'd0);
        chk("clear_start_state", 64'(fsm_state), 64'd0);
        repeat (5) @(negedge clock);
        chk("clear_start_idle", 64'(fsm_state), 64'd0);

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
